// File: rtl/z_core_mem_arbiter_if.sv
// Simple memory-port bundle (req/payload out, rdata/ready/busy back) shared by the
// arbiter's requester ports (slave side) and its memory-facing port (master side).
interface z_core_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  req;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  busy;

  modport master (
    output req, wen, addr, wdata, wstrb,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, wen, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/z_core_mem_arbiter.sv
// Two-requester arbiter in front of the single axil_master memory port.
// Tie policy: Z_CORE_MEM_ARB_RR_EN defined = round-robin, undefined = port 0 priority.
module z_core_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  z_core_mem_arbiter_if.slave  s0,
  z_core_mem_arbiter_if.slave  s1,
  z_core_mem_arbiter_if.master m,
  output logic [1:0]           arb_owner
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  state_t state, state_nx;
  logic   grant;
  logic   win1;
  logic   tie1;
  logic   last_grant;

`ifdef Z_CORE_MEM_ARB_RR_EN
  assign tie1 = ~last_grant;
`else
  logic unused_last_grant;
  assign tie1              = 1'b0;
  assign unused_last_grant = last_grant;
`endif

  // Port 1 wins when it is alone, or on a tie that the policy hands to it.
  assign win1 = s1.req & (~s0.req | tie1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    m.req    = 1'b0;
    s0.ready = 1'b0;
    s1.ready = 1'b0;
    case (state)
      IDLE: begin
        if ((s0.req | s1.req) && !m.busy) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        m.req    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (m.ready) state_nx = RESP;
      end
      RESP: begin
        s0.ready = arb_owner[0];
        s1.ready = arb_owner[1];
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Payload, owner and per-port read data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m.wen      <= 1'b0;
      m.addr     <= '0;
      m.wdata    <= '0;
      m.wstrb    <= '0;
      s0.rdata   <= '0;
      s1.rdata   <= '0;
      arb_owner  <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      if (grant) begin
        m.wen     <= win1 ? s1.wen   : s0.wen;
        m.addr    <= win1 ? s1.addr  : s0.addr;
        m.wdata   <= win1 ? s1.wdata : s0.wdata;
        m.wstrb   <= win1 ? s1.wstrb : s0.wstrb;
        arb_owner <= win1 ? 2'b10 : 2'b01;
      end
      if (state == WAIT && m.ready) begin
        if (arb_owner[1]) s1.rdata <= m.rdata;
        else              s0.rdata <= m.rdata;
      end
      if (state == RESP) begin
        last_grant <= arb_owner[1];
        arb_owner  <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Directed bench for z_core_mem_arbiter: cycle table plus tie, reset-abort sequences.
module tb_z_core_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] arb_owner;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  z_core_mem_arbiter_if s0_bus ();
  z_core_mem_arbiter_if s1_bus ();
  z_core_mem_arbiter_if m_bus ();

  z_core_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .s0        (s0_bus),
    .s1        (s1_bus),
    .m         (m_bus),
    .arb_owner (arb_owner)
  );

  typedef struct {
    string       name;
    logic        r0, r1, busy, mrdy;
    logic [31:0] mrdata;
    logic        e_mreq, e_rdy0, e_rdy1;
    logic [1:0]  e_own;
    logic        chk_pay, e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t v(string nm, logic r0, logic r1, logic busy, logic mrdy,
                             logic [31:0] mrdata, logic e_mreq, logic e_rdy0, logic e_rdy1,
                             logic [1:0] e_own, logic chk_pay, logic e_wen, logic [31:0] e_addr,
                             logic [31:0] e_wdata, logic [3:0] e_strb, logic [31:0] e_rd0,
                             logic [31:0] e_rd1);
    vec_t t;
    t.name = nm; t.r0 = r0; t.r1 = r1; t.busy = busy; t.mrdy = mrdy; t.mrdata = mrdata;
    t.e_mreq = e_mreq; t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1; t.e_own = e_own;
    t.chk_pay = chk_pay; t.e_wen = e_wen; t.e_addr = e_addr; t.e_wdata = e_wdata;
    t.e_strb = e_strb; t.e_rd0 = e_rd0; t.e_rd1 = e_rd1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] t3_own [4];
  bit         found;

  initial begin
    reset = 1'b1;
    s0_bus.req = 0; s0_bus.wen = 0; s0_bus.addr = 32'h100; s0_bus.wdata = 32'hAAAA5555;
    s0_bus.wstrb = 4'hF; s0_bus.busy = 0;
    s1_bus.req = 0; s1_bus.wen = 1; s1_bus.addr = 32'h200; s1_bus.wdata = 32'h12345678;
    s1_bus.wstrb = 4'b0011; s1_bus.busy = 0;
    m_bus.rdata = 0; m_bus.ready = 0; m_bus.busy = 0;

    //            name        r0 r1 bsy rdy mrdata        mreq r0 r1 own   pay wen addr     wdata         strb rd0           rd1
    tbl[0]  = v("reset",      0, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        32'h0);
    tbl[1]  = v("t1_c0",      1, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        32'h0);
    tbl[2]  = v("t1_issue",   1, 0, 0,  0,  32'h0,        1,   0, 0, 2'b01, 1, 0, 32'h100, 32'hAAAA5555, 4'hF, 32'h0,        32'h0);
    tbl[3]  = v("t1_wait",    1, 0, 0,  0,  32'h0,        0,   0, 0, 2'b01, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        32'h0);
    tbl[4]  = v("t1_mrdy",    1, 0, 0,  1,  32'hDEADBEEF, 0,   0, 0, 2'b01, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        32'h0);
    tbl[5]  = v("t1_resp",    1, 0, 0,  0,  32'h0,        0,   1, 0, 2'b01, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[6]  = v("t1_idle",    0, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[7]  = v("t6_inject",  0, 0, 0,  1,  32'h0BAD0BAD, 0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[8]  = v("t6_after",   0, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[9]  = v("t4_busy0",   1, 0, 1,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[10] = v("t4_busy1",   1, 0, 1,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[11] = v("t4_fall",    1, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[12] = v("t4_issue",   1, 0, 0,  0,  32'h0,        1,   0, 0, 2'b01, 1, 0, 32'h100, 32'hAAAA5555, 4'hF, 32'hDEADBEEF, 32'h0);
    tbl[13] = v("t4_mrdy",    1, 0, 0,  1,  32'h00004444, 0,   0, 0, 2'b01, 0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEEF, 32'h0);
    tbl[14] = v("t4_resp",    0, 0, 0,  0,  32'h0,        0,   1, 0, 2'b01, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'h0);
    tbl[15] = v("t4_idle",    0, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'h0);
    tbl[16] = v("t2_c0",      0, 1, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'h0);
    tbl[17] = v("t2_issue",   0, 1, 0,  0,  32'h0,        1,   0, 0, 2'b10, 1, 1, 32'h200, 32'h12345678, 4'h3, 32'h00004444, 32'h0);
    tbl[18] = v("t2_mrdy",    0, 1, 0,  1,  32'hCAFE0001, 0,   0, 0, 2'b10, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'h0);
    tbl[19] = v("t2_resp",    0, 0, 0,  0,  32'h0,        0,   0, 1, 2'b10, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'hCAFE0001);
    tbl[20] = v("t2_idle",    0, 0, 0,  0,  32'h0,        0,   0, 0, 2'b00, 0, 0, 32'h0,   32'h0,        4'h0, 32'h00004444, 32'hCAFE0001);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      s0_bus.req = tbl[i].r0; s1_bus.req = tbl[i].r1; m_bus.busy = tbl[i].busy;
      m_bus.ready = tbl[i].mrdy; m_bus.rdata = tbl[i].mrdata;
      #1;
      chk({tbl[i].name, "_mreq"}, m_bus.req, tbl[i].e_mreq);
      chk({tbl[i].name, "_rdy0"}, s0_bus.ready, tbl[i].e_rdy0);
      chk({tbl[i].name, "_rdy1"}, s1_bus.ready, tbl[i].e_rdy1);
      chk({tbl[i].name, "_own"}, arb_owner, tbl[i].e_own);
      chk({tbl[i].name, "_rd0"}, s0_bus.rdata, tbl[i].e_rd0);
      chk({tbl[i].name, "_rd1"}, s1_bus.rdata, tbl[i].e_rd1);
      if (tbl[i].chk_pay) begin
        chk({tbl[i].name, "_wen"}, m_bus.wen, tbl[i].e_wen);
        chk({tbl[i].name, "_addr"}, m_bus.addr, tbl[i].e_addr);
        chk({tbl[i].name, "_wdata"}, m_bus.wdata, tbl[i].e_wdata);
        chk({tbl[i].name, "_wstrb"}, m_bus.wstrb, tbl[i].e_strb);
      end
      nxt();
    end
    m_bus.ready = 0; m_bus.busy = 0;

    // T3: both requesters held; last winner so far was port 1.
`ifdef Z_CORE_MEM_ARB_RR_EN
    t3_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    t3_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    s0_bus.req = 1; s1_bus.req = 1;
    for (int n = 0; n < 4; n++) begin
      found = 0;
      for (int c = 0; c < 8 && !found; c++) begin
        nxt();
        #1;
        if (m_bus.req) found = 1;
      end
      chk($sformatf("t3_mreq_seen%0d", n), found, 1'b1);
      chk($sformatf("t3_owner%0d", n), arb_owner, t3_own[n]);
      nxt();
      m_bus.ready = 1; m_bus.rdata = 32'h30 + n;
      nxt();
      m_bus.ready = 0;
      #1;
      chk($sformatf("t3_rdy0_%0d", n), s0_bus.ready, t3_own[n][0]);
      chk($sformatf("t3_rdy1_%0d", n), s1_bus.ready, t3_own[n][1]);
      chk($sformatf("t3_rdata%0d", n), t3_own[n][1] ? s1_bus.rdata : s0_bus.rdata, 32'h30 + n);
      if (n == 3) begin s0_bus.req = 0; s1_bus.req = 0; end
    end
    nxt();
    #1;
    chk("t3_idle_own", arb_owner, 2'b00);
    chk("t3_idle_mreq", m_bus.req, 1'b0);

    // T5: reset while waiting for memory abandons the transaction.
    s0_bus.req = 1;
    nxt();
    #1;
    chk("t5_issue_mreq", m_bus.req, 1'b1);
    nxt();
    s0_bus.req = 0;
    #1;
    chk("t5_wait_own", arb_owner, 2'b01);
    reset = 1;
    nxt();
    reset = 0;
    #1;
    chk("t5_rst_mreq", m_bus.req, 1'b0);
    chk("t5_rst_own", arb_owner, 2'b00);
    chk("t5_rst_rdy0", s0_bus.ready, 1'b0);
    chk("t5_rst_rd0", s0_bus.rdata, 32'h0);
    chk("t5_rst_rd1", s1_bus.rdata, 32'h0);
    chk("t5_rst_addr", m_bus.addr, 32'h0);
    chk("t5_rst_wen", m_bus.wen, 1'b0);
    chk("t5_rst_wdata", m_bus.wdata, 32'h0);
    chk("t5_rst_wstrb", m_bus.wstrb, 32'h0);
    m_bus.ready = 1; m_bus.rdata = 32'h77;
    nxt();
    m_bus.ready = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("t5_late_rdy0_%0d", c), s0_bus.ready, 1'b0);
      chk($sformatf("t5_late_rdy1_%0d", c), s1_bus.ready, 1'b0);
      chk($sformatf("t5_late_rd0_%0d", c), s0_bus.rdata, 32'h0);
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
